spi_burst_ctrl: RTL and testbench

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_burst_buf.sv | 24 ++
 rtl/spi_burst_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state type, default sizing and index-width helper for the SPI burst controller.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam int MAX_BYTES_DEF = 16;
    localparam int NUM_SS_DEF    = 4;

    // Width of an index into a table of 'depth' entries; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(MAX_BYTES_DEF);
    localparam int SS_W_DEF  = idx_width(NUM_SS_DEF);

    // Last watchdog value before the timeout edge: err rises 65535 cycles after WAIT entry.
    localparam logic [15:0] WDOG_LIMIT = 16'hFFFE;

endpackage

// File: rtl/spi_burst_buf.sv
// Byte buffer with one synchronous write port and one combinational read port.
module spi_burst_buf
    import spi_pkg::*;
#(
    parameter int DEPTH = MAX_BYTES_DEF,
    localparam int AW   = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst controller: sequences slave select, setup/hold gaps and a byte engine over a TX/RX buffer.
// Optional watchdog on the byte engine is compiled in with `define SPI_BURST_WDOG_EN.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int NUM_SS    = NUM_SS_DEF,
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    localparam int IW       = idx_width(MAX_BYTES),
    localparam int SW       = idx_width(NUM_SS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IW-1:0]     cmd_len,
    input  logic [SW-1:0]     cmd_ss,
    input  logic              cmd_keep_ss,
    input  logic              tx_wr,
    input  logic [IW-1:0]     tx_waddr,
    input  logic [7:0]        tx_wdata,
    input  logic [IW-1:0]     rx_raddr,
    output logic [7:0]        rx_rdata,
    input  logic [7:0]        cs_gap,
    output logic              busy,
    output logic              done_tick,
    output logic              err,
    output logic              m_start,
    output logic [7:0]        m_din,
    input  logic              m_ready,
    input  logic              m_done_tick,
    input  logic [7:0]        m_dout,
    output logic [NUM_SS-1:0] ss_n
);

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt, len, len_nxt;
    logic [SW-1:0]     ss_sel, ss_sel_nxt;
    logic              keep, keep_nxt;
    logic [7:0]        gap_cnt, gap_nxt;
    logic [NUM_SS-1:0] ss_n_nxt;
    logic              m_start_nxt, done_nxt, rx_wr;
    logic [7:0]        m_din_nxt, tx_rdata;

`ifdef SPI_BURST_WDOG_EN
    logic [15:0] wdog, wdog_nxt;
    logic        err_r, err_nxt;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    spi_burst_buf #(.DEPTH(MAX_BYTES)) u_tx (
        .clk(clk), .wr(tx_wr), .waddr(tx_waddr), .wdata(tx_wdata),
        .raddr(idx), .rdata(tx_rdata)
    );

    spi_burst_buf #(.DEPTH(MAX_BYTES)) u_rx (
        .clk(clk), .wr(rx_wr), .waddr(idx), .wdata(m_dout),
        .raddr(rx_raddr), .rdata(rx_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len       <= '0;
            ss_sel    <= '0;
            keep      <= 1'b0;
            gap_cnt   <= '0;
            ss_n      <= '1;
            m_start   <= 1'b0;
            m_din     <= '0;
            done_tick <= 1'b0;
`ifdef SPI_BURST_WDOG_EN
            wdog      <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            len       <= len_nxt;
            ss_sel    <= ss_sel_nxt;
            keep      <= keep_nxt;
            gap_cnt   <= gap_nxt;
            ss_n      <= ss_n_nxt;
            m_start   <= m_start_nxt;
            m_din     <= m_din_nxt;
            done_tick <= done_nxt;
`ifdef SPI_BURST_WDOG_EN
            wdog      <= wdog_nxt;
            err_r     <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        len_nxt     = len;
        ss_sel_nxt  = ss_sel;
        keep_nxt    = keep;
        gap_nxt     = gap_cnt;
        ss_n_nxt    = ss_n;
        m_start_nxt = 1'b0;
        m_din_nxt   = m_din;
        done_nxt    = 1'b0;
        rx_wr       = 1'b0;
`ifdef SPI_BURST_WDOG_EN
        wdog_nxt    = wdog;
        err_nxt     = err_r;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_nxt    = cmd_len;
                    ss_sel_nxt = cmd_ss;
                    keep_nxt   = cmd_keep_ss;
                    idx_nxt    = '0;
                    gap_nxt    = '0;
                    // Whole vector is rebuilt so a kept select moves to the new slave in one edge.
                    ss_n_nxt         = '1;
                    ss_n_nxt[cmd_ss] = 1'b0;
                    state_nxt  = ST_SETUP;
`ifdef SPI_BURST_WDOG_EN
                    err_nxt    = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (gap_cnt == cs_gap) state_nxt = ST_LAUNCH;
                else                   gap_nxt   = gap_cnt + 8'd1;
            end
            ST_LAUNCH: begin
                if (m_ready) begin
                    m_start_nxt = 1'b1;
                    m_din_nxt   = tx_rdata;
                    state_nxt   = ST_WAIT;
`ifdef SPI_BURST_WDOG_EN
                    wdog_nxt    = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (m_done_tick) begin
                    rx_wr = 1'b1;
                    if (idx == len) begin
                        gap_nxt   = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = ST_LAUNCH;
                    end
                end
`ifdef SPI_BURST_WDOG_EN
                else if (wdog == WDOG_LIMIT) begin
                    err_nxt   = 1'b1;
                    ss_n_nxt  = '1;
                    state_nxt = ST_IDLE;
                end else begin
                    wdog_nxt = wdog + 16'd1;
                end
`endif
            end
            ST_HOLD: begin
                if (gap_cnt == cs_gap) begin
                    if (!keep) ss_n_nxt[ss_sel] = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: byte-engine model echoing din^0x99, directed burst table, hand sequences and random bursts.
module tb_spi_burst_ctrl;

    localparam int NUM_SS    = 4;
    localparam int MAX_BYTES = 16;
    localparam int IW        = 4;
    localparam int SW        = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_keep_ss;
    logic [IW-1:0]     cmd_len;
    logic [SW-1:0]     cmd_ss;
    logic              tx_wr;
    logic [IW-1:0]     tx_waddr, rx_raddr;
    logic [7:0]        tx_wdata, rx_rdata, cs_gap;
    logic              busy, done_tick, err, m_start, m_ready, m_done_tick;
    logic [7:0]        m_din, m_dout;
    logic [NUM_SS-1:0] ss_n;

    spi_burst_ctrl #(.NUM_SS(NUM_SS), .MAX_BYTES(MAX_BYTES)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_ss(cmd_ss), .cmd_keep_ss(cmd_keep_ss),
        .tx_wr(tx_wr), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
        .rx_raddr(rx_raddr), .rx_rdata(rx_rdata), .cs_gap(cs_gap),
        .busy(busy), .done_tick(done_tick), .err(err),
        .m_start(m_start), .m_din(m_din), .m_ready(m_ready),
        .m_done_tick(m_done_tick), .m_dout(m_dout), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] tx_model [MAX_BYTES];
    logic [7:0] start_log [$];
    int         eng_lat = 0;
    int         eng_cnt = 0;
    bit         eng_busy = 1'b0;
    bit         ready_block = 1'b0;
    bit         suppress_done = 1'b0;
    logic [7:0] eng_byte = '0;

    int         done_cnt = 0, rxw_cnt = 0, ss_bad = 0, two_low = 0, ss1_high = 0;
    bit         keep_watch = 1'b0;
    logic [3:0] exp_sel = 4'hF;

    typedef struct {
        int         len;
        int         ss;
        bit         keep;
        int         gap;
        int         lat;
        int         base;
        logic [3:0] exp_ss;
    } vec_t;

    vec_t vecs [6];

    // Byte engine: accepts a start when idle, answers eng_lat cycles later with din^0x99.
    initial begin
        m_ready = 1'b1; m_done_tick = 1'b0; m_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            m_done_tick = 1'b0;
            if (reset) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    eng_busy = 1'b0;
                    if (!suppress_done) begin
                        m_done_tick = 1'b1;
                        m_dout      = eng_byte ^ 8'h99;
                    end
                end else begin
                    eng_cnt--;
                end
            end else if (m_start) begin
                eng_busy = 1'b1;
                eng_byte = m_din;
                eng_cnt  = eng_lat;
                start_log.push_back(m_din);
            end
            m_ready = !eng_busy && !ready_block;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!$onehot0(~ss_n))                 two_low  <= two_low + 1;
            if (busy && (ss_n !== exp_sel))       ss_bad   <= ss_bad + 1;
            if (done_tick)                        done_cnt <= done_cnt + 1;
            if (m_done_tick)                      rxw_cnt  <= rxw_cnt + 1;
            if (keep_watch && ss_n[1])            ss1_high <= ss1_high + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input int base, input bit rnd);
        for (int i = 0; i < MAX_BYTES; i++) begin
            @(negedge clk);
            tx_wr    = 1'b1;
            tx_waddr = IW'(i);
            tx_wdata = rnd ? 8'($urandom) : 8'(base + i);
            tx_model[i] = tx_wdata;
        end
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic issue_cmd(input int len, input int ss, input bit keep, input int gap);
        @(negedge clk);
        cmd_len     = IW'(len);
        cmd_ss      = SW'(ss);
        cmd_keep_ss = keep;
        cs_gap      = 8'(gap);
        cmd_valid   = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
        end while (done_tick !== 1'b1 && cyc < 4000);
    endtask

    // Runs one burst and checks it against the spec-level expectation built from tx_model.
    task automatic apply_stimulus(input int len, input int ss, input bit keep, input int gap,
                                  input int lat, input logic [3:0] exp_final, input string tag);
        int         cyc, exp_cyc, done0, rxw0, errs;
        logic [3:0] sel;
        sel     = 4'b0001 << ss;
        exp_sel = ~sel;
        eng_lat = lat;
        start_log.delete();
        done0 = done_cnt;
        rxw0  = rxw_cnt;
        issue_cmd(len, ss, keep, gap);
        check_output({tag, " cmd_ready idle"}, cmd_ready, 1);
        wait_done(cyc);
        exp_cyc = 2 * (gap + 1) + (len + 1) * (3 + lat) + 1;
        check_output({tag, " cycles to done"}, cyc, exp_cyc);
        check_output({tag, " ss_n after"}, ss_n, exp_final);
        check_output({tag, " busy after"}, busy, 0);
        check_output({tag, " err"}, err, 0);
        @(negedge clk);
        check_output({tag, " done pulse width"}, done_tick, 0);
        check_output({tag, " done count"}, done_cnt - done0, 1);
        check_output({tag, " rx writes"}, rxw_cnt - rxw0, len + 1);
        check_output({tag, " start count"}, start_log.size(), len + 1);
        errs = 0;
        for (int i = 0; i < start_log.size() && i <= len; i++)
            if (start_log[i] !== tx_model[i]) errs++;
        check_output({tag, " m_din order"}, errs, 0);
        for (int i = 0; i <= len; i++) begin
            rx_raddr = IW'(i);
            #1;
            check_output($sformatf("%s rx[%0d]", tag, i), rx_rdata, tx_model[i] ^ 8'h99);
        end
    endtask

    initial begin
        int         cyc, k, len, ss, gap, lat;
        bit         keep;
        logic [3:0] sel;

        vecs[0] = '{0,  2, 1'b0, 3,   1, 'hA5, 4'b1111};
        vecs[1] = '{15, 0, 1'b0, 0,   0, 'h00, 4'b1111};
        vecs[2] = '{2,  1, 1'b1, 2,   2, 'h30, 4'b1101};
        vecs[3] = '{3,  1, 1'b1, 1,   0, 'h50, 4'b1101};
        vecs[4] = '{1,  3, 1'b0, 0,   1, 'h70, 4'b1111};
        vecs[5] = '{0,  0, 1'b0, 255, 0, 'hC0, 4'b1111};

        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_ss = '0; cmd_keep_ss = 1'b0;
        tx_wr = 1'b0; tx_waddr = '0; tx_wdata = '0; rx_raddr = '0; cs_gap = '0;
        repeat (2) @(negedge clk);
        check_output("reset cmd_ready", cmd_ready, 1);
        check_output("reset busy", busy, 0);
        check_output("reset ss_n", ss_n, 4'hF);
        check_output("reset m_start", m_start, 0);
        check_output("reset m_din", m_din, 0);
        check_output("reset done_tick", done_tick, 0);
        check_output("reset err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            load_tx(vecs[i].base, 1'b0);
            apply_stimulus(vecs[i].len, vecs[i].ss, vecs[i].keep, vecs[i].gap, vecs[i].lat,
                           vecs[i].exp_ss, $sformatf("vec%0d", i));
            if (i == 2) keep_watch = 1'b1;
            if (i == 3) keep_watch = 1'b0;
        end
        @(negedge clk);
        check_output("keep ss1 continuous", ss1_high, 0);

        // m_ready held low while LAUNCH waits; a second command during the burst must be ignored.
        load_tx(0, 1'b1);
        ready_block = 1'b1;
        exp_sel     = 4'b1110;
        eng_lat     = 0;
        start_log.delete();
        @(negedge clk);
        issue_cmd(1, 0, 1'b0, 0);
        @(negedge clk);
        cmd_ss = 2'd3; cmd_keep_ss = 1'b1;
        repeat (50) @(negedge clk);
        check_output("stall no m_start", start_log.size(), 0);
        check_output("stall cmd_ready", cmd_ready, 0);
        check_output("stall busy", busy, 1);
        check_output("stall ss_n", ss_n, 4'b1110);
        cmd_valid   = 1'b0;
        ready_block = 1'b0;
        wait_done(cyc);
        check_output("stall done seen", done_tick, 1);
        check_output("stall start count", start_log.size(), 2);
        check_output("stall ss_n after", ss_n, 4'hF);

        // TX rewrite of the byte in flight must not disturb it; the new value is used next time.
        load_tx('h11, 1'b0);
        exp_sel = 4'b1011;
        eng_lat = 6;
        start_log.delete();
        issue_cmd(0, 2, 1'b0, 0);
        k = 0;
        while (start_log.size() == 0 && k < 200) begin @(negedge clk); cmd_valid = 1'b0; k++; end
        tx_wr = 1'b1; tx_waddr = '0; tx_wdata = 8'hEE;
        @(negedge clk);
        tx_wr = 1'b0;
        wait_done(cyc);
        check_output("inflight m_din", (start_log.size() > 0) ? start_log[0] : 8'h00, 8'h11);
        rx_raddr = '0;
        #1;
        check_output("inflight rx", rx_rdata, 8'h11 ^ 8'h99);
        tx_model[0] = 8'hEE;
        apply_stimulus(0, 2, 1'b0, 1, 0, 4'hF, "rewrite");

        // Reset asserted while byte 5 of an 8-byte burst waits on the engine.
        load_tx(0, 1'b1);
        exp_sel = 4'b1110;
        eng_lat = 3;
        start_log.delete();
        issue_cmd(7, 0, 1'b0, 1);
        k = 0;
        while (start_log.size() < 5 && k < 500) begin @(negedge clk); cmd_valid = 1'b0; k++; end
        check_output("rst reached byte5", start_log.size(), 5);
        check_output("rst busy before", busy, 1);
        reset = 1'b1;
        #1;
        check_output("rst ss_n", ss_n, 4'hF);
        check_output("rst busy", busy, 0);
        check_output("rst m_start", m_start, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("rst cmd_ready after", cmd_ready, 1);
        check_output("rst ss_n after", ss_n, 4'hF);

        for (int r = 0; r < 20; r++) begin
            len  = $urandom_range(0, 15);
            ss   = $urandom_range(0, 3);
            keep = 1'($urandom);
            gap  = $urandom_range(0, 5);
            lat  = $urandom_range(0, 3);
            sel  = 4'b0001 << ss;
            load_tx(0, 1'b1);
            apply_stimulus(len, ss, keep, gap, lat, keep ? ~sel : 4'hF, $sformatf("rnd%0d", r));
        end
        check_output("never two selects low", two_low, 0);
        check_output("select during busy", ss_bad, 0);

`ifdef SPI_BURST_WDOG_EN
        load_tx(0, 1'b1);
        exp_sel       = 4'b1110;
        suppress_done = 1'b1;
        eng_lat       = 0;
        k = done_cnt;
        issue_cmd(0, 0, 1'b0, 0);
        cyc = 0;
        while (m_start !== 1'b1 && cyc < 100) begin @(negedge clk); cmd_valid = 1'b0; cyc++; end
        check_output("wdog err clear at wait", err, 0);
        cyc = 0;
        while (err !== 1'b1 && cyc < 70000) begin @(negedge clk); cyc++; end
        check_output("wdog cycles", cyc, 65535);
        check_output("wdog ss_n", ss_n, 4'hF);
        check_output("wdog busy", busy, 0);
        @(negedge clk);
        check_output("wdog no done", done_cnt - k, 0);
        check_output("wdog err sticky", err, 1);
        suppress_done = 1'b0;
        apply_stimulus(1, 3, 1'b0, 0, 0, 4'hF, "wdog recover");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
